// File: rtl/game_round_ctrl.sv
// Round sequencer for the binary-to-decimal switch game: walks the puzzle ROM,
// runs the per-round countdown, judges answers and keeps BCD score and lives.
module game_round_ctrl #(
    parameter int TICK_DIV      = 50_000_000,
    parameter int ROUND_SECS    = 9,
    parameter int NUM_PUZZLES   = 21,
    parameter int LIVES         = 3,
    parameter int RESULT_CYCLES = 8
) (
    input  logic       clk50,
    input  logic       reset,
    input  logic       start,
    input  logic       submit,
    input  logic [7:0] answer,
    input  logic [7:0] puz_value,
    output logic [4:0] puz_idx,
    output logic       puz_valid,
    output logic [3:0] secs_left,
    output logic [3:0] score_ones,
    output logic [3:0] score_tens,
    output logic [1:0] lives,
    output logic       correct_p,
    output logic       wrong_p,
    output logic       game_over,
    output logic       win,
    output logic [2:0] dbg_state
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int RW = (RESULT_CYCLES > 1) ? $clog2(RESULT_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [RW-1:0] RES_LAST   = RW'(RESULT_CYCLES - 1);
    localparam logic [3:0]    SECS_INIT  = 4'(ROUND_SECS);
    localparam logic [1:0]    LIVES_INIT = 2'(LIVES);
    localparam logic [4:0]    IDX_LAST   = 5'(NUM_PUZZLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        PLAY   = 3'd2,
        RESULT = 3'd3,
        OVER   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [RW-1:0] res_q, res_d;
    logic [3:0]    secs_q, secs_d;
    logic [3:0]    ones_q, ones_d;
    logic [3:0]    tens_q, tens_d;
    logic [1:0]    lives_q, lives_d;
    logic [4:0]    idx_q, idx_d;
    logic          win_q, win_d;
    logic          corr_q, corr_d;
    logic          wrong_q, wrong_d;
    logic          last_ok_q, last_ok_d;

    logic tick_end;
    logic judge;
    logic hit;

    assign tick_end = (tick_q == TICK_LAST);
    // A round is judged either by a submit or by the final second running out.
    assign judge = submit || (tick_end && (secs_q <= 4'd1));
    assign hit   = submit && (answer == puz_value);

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        res_d     = res_q;
        secs_d    = secs_q;
        ones_d    = ones_q;
        tens_d    = tens_q;
        lives_d   = lives_q;
        idx_d     = idx_q;
        win_d     = win_q;
        corr_d    = 1'b0;
        wrong_d   = 1'b0;
        last_ok_d = last_ok_q;
        case (state_q)
            IDLE, OVER: begin
                if (start) begin
                    state_d = LOAD;
                    ones_d  = 4'd0;
                    tens_d  = 4'd0;
                    lives_d = LIVES_INIT;
                    idx_d   = 5'd0;
                    win_d   = 1'b0;
                end
            end
            LOAD: begin
                state_d = PLAY;
                secs_d  = SECS_INIT;
                tick_d  = '0;
            end
            PLAY: begin
                if (judge) begin
                    state_d   = RESULT;
                    res_d     = '0;
                    last_ok_d = hit;
                    if (hit) begin
                        corr_d = 1'b1;
                        if (!(ones_q == 4'd9 && tens_q == 4'd9)) begin
                            if (ones_q == 4'd9) begin
                                ones_d = 4'd0;
                                tens_d = tens_q + 4'd1;
                            end else begin
                                ones_d = ones_q + 4'd1;
                            end
                        end
                    end else begin
                        wrong_d = 1'b1;
                        lives_d = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
                        if (!submit) begin
                            secs_d = 4'd0;
                        end
                    end
                end else if (tick_end) begin
                    tick_d = '0;
                    secs_d = secs_q - 4'd1;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            RESULT: begin
                if (res_q == RES_LAST) begin
                    if (lives_q == 2'd0) begin
                        state_d = OVER;
                    end else if (last_ok_q && idx_q == IDX_LAST) begin
                        state_d = OVER;
                        win_d   = 1'b1;
                    end else begin
                        state_d = LOAD;
                        if (last_ok_q) begin
                            idx_d = idx_q + 5'd1;
                        end
                    end
                end else begin
                    res_d = res_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            tick_q    <= '0;
            res_q     <= '0;
            secs_q    <= SECS_INIT;
            ones_q    <= 4'd0;
            tens_q    <= 4'd0;
            lives_q   <= LIVES_INIT;
            idx_q     <= 5'd0;
            win_q     <= 1'b0;
            corr_q    <= 1'b0;
            wrong_q   <= 1'b0;
            last_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            res_q     <= res_d;
            secs_q    <= secs_d;
            ones_q    <= ones_d;
            tens_q    <= tens_d;
            lives_q   <= lives_d;
            idx_q     <= idx_d;
            win_q     <= win_d;
            corr_q    <= corr_d;
            wrong_q   <= wrong_d;
            last_ok_q <= last_ok_d;
        end
    end

    assign puz_idx    = idx_q;
    assign puz_valid  = (state_q == PLAY);
    assign secs_left  = secs_q;
    assign score_ones = ones_q;
    assign score_tens = tens_q;
    assign lives      = lives_q;
    assign correct_p  = corr_q;
    assign wrong_p    = wrong_q;
    assign game_over  = (state_q == OVER);
    assign win        = win_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Bench for game_round_ctrl: round-level behavioural model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_game_round_ctrl;

    localparam int TICK_DIV      = 4;
    localparam int ROUND_SECS    = 3;
    localparam int NUM_PUZZLES   = 3;
    localparam int LIVES         = 2;
    localparam int RESULT_CYCLES = 2;

    logic       clk50 = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       submit = 1'b0;
    logic [7:0] answer = 8'd0;
    logic [7:0] puz_value;
    logic [4:0] puz_idx;
    logic       puz_valid;
    logic [3:0] secs_left;
    logic [3:0] score_ones;
    logic [3:0] score_tens;
    logic [1:0] lives;
    logic       correct_p;
    logic       wrong_p;
    logic       game_over;
    logic       win;
    logic [2:0] dbg_state;

    logic [7:0] rom [0:2];
    initial begin
        rom[0] = 8'h01;
        rom[1] = 8'h5A;
        rom[2] = 8'hC3;
    end

    assign puz_value = (puz_idx < 5'd3) ? rom[puz_idx] : 8'h00;

    game_round_ctrl #(
        .TICK_DIV(TICK_DIV), .ROUND_SECS(ROUND_SECS), .NUM_PUZZLES(NUM_PUZZLES),
        .LIVES(LIVES), .RESULT_CYCLES(RESULT_CYCLES)
    ) dut (
        .clk50(clk50), .reset(reset), .start(start), .submit(submit),
        .answer(answer), .puz_value(puz_value), .puz_idx(puz_idx),
        .puz_valid(puz_valid), .secs_left(secs_left), .score_ones(score_ones),
        .score_tens(score_tens), .lives(lives), .correct_p(correct_p),
        .wrong_p(wrong_p), .game_over(game_over), .win(win), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk50 = ~clk50;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // round-level model: mode 0 idle, 1 load, 2 play, 3 result, 4 over
    int m_mode, m_idx, m_secs, m_score, m_lives, m_play_cyc, m_res_left;
    bit m_win, m_corr, m_wrong, m_last_ok, m_ok;

    always @(posedge clk50 or posedge reset) begin
        if (reset) begin
            m_mode = 0; m_idx = 0; m_secs = ROUND_SECS; m_score = 0; m_lives = LIVES;
            m_win = 0; m_corr = 0; m_wrong = 0; m_play_cyc = 0; m_res_left = 0; m_last_ok = 0;
        end else begin
            m_corr = 0;
            m_wrong = 0;
            case (m_mode)
                0, 4: if (start) begin
                    m_mode = 1; m_score = 0; m_lives = LIVES; m_idx = 0; m_win = 0;
                end
                1: begin
                    m_mode = 2; m_play_cyc = 0; m_secs = ROUND_SECS;
                end
                2: begin
                    m_play_cyc++;
                    if (submit || (m_play_cyc % TICK_DIV == 0 && m_secs == 1)) begin
                        if (!submit) m_secs = 0;
                        m_ok = submit && (answer == rom[m_idx]);
                        m_last_ok = m_ok;
                        if (m_ok) begin
                            m_corr = 1;
                            if (m_score < 99) m_score++;
                        end else begin
                            m_wrong = 1;
                            if (m_lives > 0) m_lives--;
                        end
                        m_mode = 3;
                        m_res_left = RESULT_CYCLES;
                    end else if (m_play_cyc % TICK_DIV == 0) begin
                        m_secs--;
                    end
                end
                3: begin
                    m_res_left--;
                    if (m_res_left == 0) begin
                        if (m_lives == 0) m_mode = 4;
                        else if (m_last_ok && m_idx == NUM_PUZZLES - 1) begin
                            m_mode = 4; m_win = 1;
                        end else begin
                            if (m_last_ok) m_idx++;
                            m_mode = 1;
                        end
                    end
                end
                default: m_mode = 0;
            endcase
        end
    end

    // scoreboard compare, every cycle on the falling edge
    always @(negedge clk50) begin
        chk("state", 32'(dbg_state), 32'(m_mode));
        chk("puz_idx", 32'(puz_idx), 32'(m_idx));
        chk("puz_valid", 32'(puz_valid), 32'(m_mode == 2));
        chk("secs_left", 32'(secs_left), 32'(m_secs));
        chk("score_ones", 32'(score_ones), 32'(m_score % 10));
        chk("score_tens", 32'(score_tens), 32'(m_score / 10));
        chk("lives", 32'(lives), 32'(m_lives));
        chk("correct_p", 32'(correct_p), 32'(m_corr));
        chk("wrong_p", 32'(wrong_p), 32'(m_wrong));
        chk("game_over", 32'(game_over), 32'(m_mode == 4));
        chk("win", 32'(win), 32'(m_win));
    end

    // driver tasks
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk50);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_submit(input logic [7:0] a);
        answer = a;
        submit = 1'b1;
        tick();
        submit = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick();
        chk("lit_reset_state", 32'(dbg_state), 32'd0);
        chk("lit_reset_secs", 32'(secs_left), 32'd3);
        chk("lit_reset_lives", 32'(lives), 32'd2);

        // start -> LOAD -> PLAY
        pulse_start();
        chk("lit_load", 32'(dbg_state), 32'd1);
        tick();
        chk("lit_play_valid", 32'(puz_valid), 32'd1);
        chk("lit_play_secs", 32'(secs_left), 32'd3);
        chk("lit_play_idx", 32'(puz_idx), 32'd0);

        // correct answer
        pulse_submit(8'h01);
        chk("lit_correct_p", 32'(correct_p), 32'd1);
        chk("lit_score_1", 32'(score_ones), 32'd1);
        tick();
        chk("lit_result_hold", 32'(dbg_state), 32'd3);
        tick();
        chk("lit_next_load", 32'(dbg_state), 32'd1);
        chk("lit_next_idx", 32'(puz_idx), 32'd1);
        tick();

        // wrong answer, retry same puzzle
        pulse_submit(8'h00);
        chk("lit_wrong_p", 32'(wrong_p), 32'd1);
        chk("lit_lives_1", 32'(lives), 32'd1);
        tick(3);
        chk("lit_retry_idx", 32'(puz_idx), 32'd1);
        chk("lit_retry_secs", 32'(secs_left), 32'd3);

        // timeout
        tick(4);
        chk("lit_secs_2", 32'(secs_left), 32'd2);
        tick(4);
        chk("lit_secs_1", 32'(secs_left), 32'd1);
        tick(4);
        chk("lit_timeout_wrong", 32'(wrong_p), 32'd1);
        chk("lit_timeout_secs", 32'(secs_left), 32'd0);
        chk("lit_lives_0", 32'(lives), 32'd0);
        tick(2);
        chk("lit_over", 32'(game_over), 32'd1);
        chk("lit_over_nowin", 32'(win), 32'd0);
        pulse_submit(8'h01);
        chk("lit_over_ignores_submit", 32'(dbg_state), 32'd4);

        // solve all puzzles
        pulse_start();
        tick();
        pulse_submit(8'h01);
        tick(3);
        pulse_submit(8'h5A);
        tick(3);
        chk("lit_idx_2", 32'(puz_idx), 32'd2);
        pulse_submit(8'hC3);
        tick(2);
        chk("lit_win_over", 32'(game_over), 32'd1);
        chk("lit_win", 32'(win), 32'd1);
        chk("lit_score_3", 32'(score_ones), 32'd3);
        pulse_start();
        chk("lit_restart_score", 32'(score_ones), 32'd0);
        chk("lit_restart_idx", 32'(puz_idx), 32'd0);
        chk("lit_restart_win", 32'(win), 32'd0);

        // submit on the terminal tick cycle
        tick(4);
        pulse_submit(8'h01);
        chk("lit_tick_submit_corr", 32'(correct_p), 32'd1);
        chk("lit_tick_submit_secs", 32'(secs_left), 32'd3);
        tick(3);
        tick(2);

        // reset mid-PLAY
        chk("lit_pre_reset_play", 32'(dbg_state), 32'd2);
        reset = 1'b1;
        #1;
        chk("lit_async_state", 32'(dbg_state), 32'd0);
        chk("lit_async_score", 32'(score_ones), 32'd0);
        chk("lit_async_idx", 32'(puz_idx), 32'd0);
        chk("lit_async_pulse", 32'(correct_p | wrong_p), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        pulse_start();
        chk("lit_after_reset_load", 32'(dbg_state), 32'd1);
        tick();
        chk("lit_after_reset_play", 32'(puz_valid), 32'd1);
        tick(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
